// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if: block-in / result-out handshake bundle of the AES round controller.
interface aes_round_ctrl_if;
  localparam int unsigned BLK_W = 128;

  logic             in_valid;
  logic             in_ready;
  logic [BLK_W-1:0] in_data;
  logic             in_decrypt;
  logic             out_valid;
  logic             out_ready;
  logic [BLK_W-1:0] out_data;

  modport master (
    output in_valid, in_data, in_decrypt, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_decrypt, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES round sequencer feeding an external combinational round datapath.
// Defining AES_ROUND_CTRL_FLUSH_EN adds a flush input that aborts the block in flight.
module aes_round_ctrl #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef AES_ROUND_CTRL_FLUSH_EN
  input  logic                 flush,
`endif
  aes_round_ctrl_if.slave      bus,
  output logic [3:0]           rk_idx,
  input  logic [127:0]         rk,
  output logic [127:0]         dp_state,
  output logic                 dp_inverse,
  output logic                 dp_final,
  input  logic [127:0]         dp_result,
  output logic                 busy
);

  localparam int unsigned BLK_W = 128;
  localparam int unsigned IDX_W = 4;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [BLK_W-1:0] state_reg;
  logic [IDX_W-1:0] r;
  logic             dir_reg;
  logic             out_valid_q;
  logic             busy_q;
  logic             inv_q;
  logic             final_q;
  logic             accept;

  // Acceptance is withheld during reset (and flush) so a handshake never completes unseen.
`ifdef AES_ROUND_CTRL_FLUSH_EN
  assign bus.in_ready = (state == IDLE) && !rst && !flush;
`else
  assign bus.in_ready = (state == IDLE) && !rst;
`endif

  assign accept        = bus.in_valid && bus.in_ready;
  assign dp_state      = state_reg;
  assign bus.out_data  = state_reg;
  assign bus.out_valid = out_valid_q;
  assign busy          = busy_q;
  assign dp_inverse    = inv_q;
  assign dp_final      = final_q;

  // Key index must follow the offered direction while idle so the whitening key is ready.
  always_comb begin
    rk_idx = '0;
    case (state)
      IDLE:    rk_idx = bus.in_decrypt ? LAST : '0;
      ROUND:   rk_idx = dir_reg ? (LAST - r) : r;
      default: rk_idx = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      state_reg   <= '0;
      r           <= '0;
      dir_reg     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      inv_q       <= 1'b0;
      final_q     <= 1'b0;
    end
`ifdef AES_ROUND_CTRL_FLUSH_EN
    else if (flush) begin
      // Abort returns to IDLE but leaves state_reg untouched.
      state       <= IDLE;
      r           <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      inv_q       <= 1'b0;
      final_q     <= 1'b0;
    end
`endif
    else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state_reg <= bus.in_data ^ rk;
            dir_reg   <= bus.in_decrypt;
            r         <= IDX_W'(1);
            state     <= ROUND;
            busy_q    <= 1'b1;
            inv_q     <= bus.in_decrypt;
            final_q   <= (LAST == IDX_W'(1));
          end
        end
        ROUND: begin
          state_reg <= dp_result;
          if (r == LAST) begin
            // Counter saturates at the final round; it is reloaded on the next accept.
            state       <= DONE;
            out_valid_q <= 1'b1;
            inv_q       <= 1'b0;
            final_q     <= 1'b0;
          end else begin
            r       <= r + IDX_W'(1);
            final_q <= ((r + IDX_W'(1)) == LAST);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          inv_q       <= 1'b0;
          final_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: transaction-level model plus bench-side AES/XOR round datapath for aes_round_ctrl.
module tb_aes_round_ctrl;

  localparam int N = 10;
  localparam logic [127:0] AES_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] AES_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] AES_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] XOR_RES = {16{8'h0b}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush_drv = 1'b0;
  logic         mode = 1'b0;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic [127:0] dp_state;
  logic [127:0] dp_result;
  logic         dp_inverse;
  logic         dp_final;
  logic         busy;

  int checks = 0;
  int fails  = 0;
  bit chk_en = 1'b0;

  aes_round_ctrl_if bus ();

  aes_round_ctrl #(.NUM_ROUNDS(N)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef AES_ROUND_CTRL_FLUSH_EN
    .flush      (flush_drv),
`endif
    .bus        (bus),
    .rk_idx     (rk_idx),
    .rk         (rk),
    .dp_state   (dp_state),
    .dp_inverse (dp_inverse),
    .dp_final   (dp_final),
    .dp_result  (dp_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- GF(2^8) and AES primitives ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] x = a;
    logic [7:0] r = 8'h01;
    if (a == 8'h00) return 8'h00;
    for (int i = 0; i < 7; i++) begin
      x = gmul(x, x);
      r = gmul(r, x);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t = {b, b};
    return t[15-n -: 8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] y = ginv(b);
    return y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] b);
    return ginv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] k, input logic fin);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[r+4*c] = a[r+4*((c+r)%4)];
    for (int c = 0; c < 4; c++) begin
      if (fin) begin
        for (int r = 0; r < 4; r++) a[r+4*c] = b[r+4*c];
      end else begin
        a[4*c]   = gmul(8'h02, b[4*c]) ^ gmul(8'h03, b[4*c+1]) ^ b[4*c+2] ^ b[4*c+3];
        a[4*c+1] = b[4*c] ^ gmul(8'h02, b[4*c+1]) ^ gmul(8'h03, b[4*c+2]) ^ b[4*c+3];
        a[4*c+2] = b[4*c] ^ b[4*c+1] ^ gmul(8'h02, b[4*c+2]) ^ gmul(8'h03, b[4*c+3]);
        a[4*c+3] = gmul(8'h03, b[4*c]) ^ b[4*c+1] ^ b[4*c+2] ^ gmul(8'h02, b[4*c+3]);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = a[i];
    return o ^ k;
  endfunction

  function automatic logic [127:0] dec_round(input logic [127:0] s, input logic [127:0] k, input logic fin);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        a[r+4*c] = isbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
    for (int i = 0; i < 16; i++) b[i] = a[i] ^ k[127-8*i -: 8];
    for (int c = 0; c < 4; c++) begin
      if (fin) begin
        for (int r = 0; r < 4; r++) a[r+4*c] = b[r+4*c];
      end else begin
        a[4*c]   = gmul(8'h0e, b[4*c]) ^ gmul(8'h0b, b[4*c+1]) ^ gmul(8'h0d, b[4*c+2]) ^ gmul(8'h09, b[4*c+3]);
        a[4*c+1] = gmul(8'h09, b[4*c]) ^ gmul(8'h0e, b[4*c+1]) ^ gmul(8'h0b, b[4*c+2]) ^ gmul(8'h0d, b[4*c+3]);
        a[4*c+2] = gmul(8'h0d, b[4*c]) ^ gmul(8'h09, b[4*c+1]) ^ gmul(8'h0e, b[4*c+2]) ^ gmul(8'h0b, b[4*c+3]);
        a[4*c+3] = gmul(8'h0b, b[4*c]) ^ gmul(8'h0d, b[4*c+1]) ^ gmul(8'h09, b[4*c+2]) ^ gmul(8'h0e, b[4*c+3]);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = a[i];
    return o;
  endfunction

  // Round key: XOR mode uses 16 copies of the index byte, AES mode the AES-128 schedule.
  function automatic logic [127:0] key_of(input logic [3:0] idx, input logic m);
    logic [31:0] w [64];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    if (!m) return {16{4'h0, idx}};
    w[0] = AES_KEY[127:96];
    w[1] = AES_KEY[95:64];
    w[2] = AES_KEY[63:32];
    w[3] = AES_KEY[31:0];
    for (int i = 4; i < 4*int'(idx) + 4; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
  endfunction

  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] k,
                                            input logic inv, input logic fin, input logic m);
    if (!m) return s ^ k;
    return inv ? dec_round(s, k, fin) : enc_round(s, k, fin);
  endfunction

  function automatic logic [127:0] ref_block(input logic [127:0] data, input logic dec, input logic m);
    logic [127:0] s = data ^ key_of(dec ? 4'(N) : 4'd0, m);
    for (int j = 1; j <= N; j++) s = round_fn(s, key_of(4'(dec ? N - j : j), m), dec, j == N, m);
    return s;
  endfunction

  // Bench-side round datapath.
  always_comb begin
    rk        = key_of(rk_idx, mode);
    dp_result = round_fn(dp_state, rk, dp_inverse, dp_final, mode);
  end

  // ---------------- transaction model ----------------
  // phase 0: idle, 1..N: round number in progress, N+1: result waiting.
  int           phase = 0;
  logic [127:0] m_s = '0;
  logic         m_dir = 1'b0;
  int           done_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      phase = 0;
      m_s   = '0;
      m_dir = 1'b0;
    end else if (flush_drv) begin
      phase = 0;
    end else if (phase == 0) begin
      if (bus.in_valid) begin
        m_dir = bus.in_decrypt;
        m_s   = bus.in_data ^ key_of(m_dir ? 4'(N) : 4'd0, mode);
        phase = 1;
      end
    end else if (phase <= N) begin
      m_s   = round_fn(m_s, key_of(4'(m_dir ? N - phase : phase), mode), m_dir, phase == N, mode);
      phase = phase + 1;
    end else if (bus.out_ready) begin
      phase    = 0;
      done_cnt = done_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",   128'(bus.in_ready),  128'(phase == 0 && !rst && !flush_drv));
      chk("busy",       128'(busy),          128'(phase != 0));
      chk("out_valid",  128'(bus.out_valid), 128'(phase == N + 1));
      chk("dp_state",   dp_state,            m_s);
      chk("dp_inverse", 128'(dp_inverse),    128'(phase >= 1 && phase <= N && m_dir));
      chk("dp_final",   128'(dp_final),      128'(phase == N));
      if (phase == 0)
        chk("rk_idx_idle", 128'(rk_idx), 128'(bus.in_decrypt ? N : 0));
      else if (phase <= N)
        chk("rk_idx_round", 128'(rk_idx), 128'(m_dir ? N - phase : phase));
      if (phase == N + 1)
        chk("out_data", bus.out_data, m_s);
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_directed(input logic [127:0] data, input logic dec, input logic [127:0] exp,
                              input int hold, input bit chk_seq);
    int lat;
    bit seen;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_data = data; bus.in_decrypt = dec; bus.out_ready = 1'b0;
    @(negedge clk);
    chk("idle_rk_idx", 128'(rk_idx), 128'(dec ? N : 0));
    chk("idle_in_ready", 128'(bus.in_ready), 128'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_data = rnd128(); bus.in_decrypt = 1'($urandom);
    lat = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) seen = 1'b1;
      else begin
        if (chk_seq) begin
          chk("seq_rk_idx", 128'(rk_idx), 128'(dec ? N - lat : lat));
          chk("seq_dp_final", 128'(dp_final), 128'(lat == N));
        end
        @(posedge clk); #1;
        bus.in_valid = 1'($urandom); bus.in_data = rnd128();
      end
    end
    chk("latency", 128'(lat), 128'(N + 1));
    chk("result", bus.out_data, exp);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'($urandom); bus.in_data = rnd128(); bus.in_decrypt = 1'($urandom);
      @(negedge clk);
      chk("hold_out_valid", 128'(bus.out_valid), 128'(1));
      chk("hold_out_data", bus.out_data, exp);
      chk("hold_in_ready", 128'(bus.in_ready), 128'(0));
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("drain_no_accept", 128'(busy), 128'(0));
    chk("drain_out_valid", 128'(bus.out_valid), 128'(0));
  endtask

  initial begin
    #2_000_000;
    fails++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    logic [127:0] d;
    logic         dec;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_decrypt = 1'b0; bus.out_ready = 1'b0;

    @(posedge clk); #1; chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1; bus.in_valid = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 128'(bus.in_ready), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_out_valid", 128'(bus.out_valid), 128'(0));
    chk("reset_state", dp_state, 128'(0));
    @(posedge clk); #1; rst = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 128'(bus.in_ready), 128'(1));

    run_directed('0, 1'b0, XOR_RES, 0, 1'b1);
    run_directed('0, 1'b1, XOR_RES, 0, 1'b1);

    @(posedge clk); #1; mode = 1'b1;
    run_directed(AES_PT, 1'b0, AES_CT, 5, 1'b1);
    run_directed(AES_CT, 1'b1, AES_PT, 0, 1'b0);

    // Reset during the fourth round cycle.
    @(posedge clk); #1; mode = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = rnd128(); bus.in_decrypt = 1'b0;
    @(posedge clk); #1; bus.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 128'(busy), 128'(0));
    chk("rst_mid_in_ready", 128'(bus.in_ready), 128'(1));
    chk("rst_mid_state", dp_state, 128'(0));
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("rst_mid_no_valid", 128'(bus.out_valid), 128'(0));
    end
    d = rnd128(); dec = 1'($urandom);
    run_directed(d, dec, ref_block(d, dec, 1'b0), 0, 1'b1);

`ifdef AES_ROUND_CTRL_FLUSH_EN
    // Flush at round 6, then a back-to-back AES block.
    @(posedge clk); #1; mode = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = rnd128(); bus.in_decrypt = 1'b0;
    @(posedge clk); #1; bus.in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    flush_drv = 1'b1;
    @(posedge clk); #1; flush_drv = 1'b0;
    @(negedge clk);
    chk("flush_busy", 128'(busy), 128'(0));
    chk("flush_out_valid", 128'(bus.out_valid), 128'(0));
    run_directed(AES_PT, 1'b0, AES_CT, 0, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b1; flush_drv = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; flush_drv = 1'b0;
    @(negedge clk);
    chk("flush_blocks_accept", 128'(busy), 128'(0));
`endif

    // Randomized traffic with occasional reset (and flush).
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      if (cyc % 250 == 0) mode = 1'($urandom);
      bus.in_valid   = 1'($urandom);
      bus.in_data    = rnd128();
      bus.in_decrypt = 1'($urandom);
      bus.out_ready  = ($urandom % 4) != 0;
      rst            = ($urandom % 150) == 0;
`ifdef AES_ROUND_CTRL_FLUSH_EN
      flush_drv      = ($urandom % 60) == 0;
`endif
    end
    @(posedge clk); #1;
    rst = 1'b0; flush_drv = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (N + 4) @(posedge clk);
    @(negedge clk);
    chk("final_idle", 128'(busy), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter NUM_ROUNDS, default 10, meaning AES round count; the only legal values SHALL be 10, 12 and 14.
REQ-002 clk  input  1  the single clock; all state SHALL update on the rising edge only.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  a block is offered.
REQ-005 in_ready  output  1  the controller accepts a block.
REQ-006 in_data  input  128  plaintext or ciphertext block.
REQ-007 in_decrypt  input  1  direction of the offered block: 0 = encrypt, 1 = decrypt.
REQ-008 rk_idx  output  4  index of the requested round key.
REQ-009 rk  input  128  round key for rk_idx, valid in the same cycle.
REQ-010 dp_state  output  128  round input to the external round datapath.
REQ-011 dp_inverse  output  1  selects the inverse round in the datapath.
REQ-012 dp_final  output  1  final round: the datapath skips (Inv)MixColumns.
REQ-013 dp_result  input  128  combinational round output of the datapath, including AddRoundKey with rk.
REQ-014 out_valid  output  1  a result is available.
REQ-015 out_ready  input  1  the consumer accepts the result.
REQ-016 out_data  output  128  result block.
REQ-017 busy  output  1  the FSM is not in IDLE.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, ROUND and DONE.
REQ-019 IDLE: in_ready=1; rk_idx = in_decrypt ? NUM_ROUNDS : 0.
REQ-020 On in_valid&&in_ready: state_reg <= in_data ^ rk; dir_reg <= in_decrypt; round counter r <= 1; next state ROUND.
REQ-021 ROUND: dp_state=state_reg; dp_inverse=dir_reg; rk_idx = dir_reg ? NUM_ROUNDS-r : r; dp_final = (r==NUM_ROUNDS).
REQ-022 ROUND, each cycle: state_reg <= dp_result and r <= r+1; when r==NUM_ROUNDS the next state SHALL be DONE.
REQ-023 DONE: out_valid=1 and out_data=state_reg, both held stable until out_ready.
REQ-024 On out_valid&&out_ready the next state SHALL be IDLE; a block offered in that cycle SHALL NOT be accepted.
REQ-025 Latency SHALL be NUM_ROUNDS+1 cycles from the accept edge to out_valid; throughput SHALL be one block per NUM_ROUNDS+2 cycles with out_ready tied to 1.
REQ-026 in_ready SHALL be 0 in ROUND and DONE; in_data and in_decrypt SHALL be ignored outside IDLE.
REQ-027 In IDLE and DONE: dp_inverse=0, dp_final=0, dp_state=state_reg.
REQ-028 r SHALL be 4 bits and SHALL never exceed NUM_ROUNDS; no wrap-around SHALL occur.

Reset
REQ-029 While rst=1: the FSM SHALL be IDLE, state_reg=0, r=0, dir_reg=0, out_valid=0, busy=0, in_ready=0.
REQ-030 In the first cycle after rst deasserts, in_ready SHALL be 1.
REQ-031 rst asserted in ROUND or DONE SHALL discard the block in flight and produce no out_valid pulse.

Configuration
REQ-032 Macro AES_ROUND_CTRL_FLUSH_EN defined: an input port flush (1 bit) SHALL be added.
REQ-033 With AES_ROUND_CTRL_FLUSH_EN defined, flush=1 SHALL force IDLE on the next edge from any state, clear out_valid and keep state_reg; rst SHALL take priority over flush.
REQ-034 With AES_ROUND_CTRL_FLUSH_EN defined, flush in IDLE coinciding with in_valid SHALL block acceptance.
REQ-035 AES_ROUND_CTRL_FLUSH_EN undefined: the flush port and its logic SHALL be absent, and behaviour SHALL be per REQ-018..031.

Verification
REQ-036 Bench datapath dp_result=dp_state^rk; rk = 16 bytes each equal to rk_idx; encrypt in_data=0 -> rk_idx sequence 0,1..10; out_data = 16 bytes of 0x0B after 11 cycles.
REQ-037 Same datapath, decrypt in_data=0 -> rk_idx sequence 10,9..0; dp_final only in the 10th ROUND cycle; out_data = 16 bytes of 0x0B.
REQ-038 Full AES bench datapath, key 000102030405060708090a0b0c0d0e0f, encrypt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a; decrypting that result -> the original plaintext.
REQ-039 out_ready held 0 for 5 cycles in DONE -> out_valid and out_data stable; in_ready=0; in_valid ignored throughout.
REQ-040 rst pulsed in the 4th ROUND cycle -> IDLE, out_valid stays 0; the next block completes correctly.
REQ-041 With AES_ROUND_CTRL_FLUSH_EN defined, flush at ROUND r=6 -> IDLE next cycle, no out_valid; a back-to-back block afterwards gives the correct result.
